// File: rtl/ddf_pkg.sv
// rtl/ddf_pkg.sv - shared tag/payload split helpers for dataflow actors
//
// Purpose: constant functions that derive the tag width and payload width
//          of a tagged token from the token width and the number of fluxes.
// Ports:   none (package)
package ddf_pkg;

   // Bits needed to carry a flux tag.
   function automatic int tag_width(input int flux);
      return $clog2(flux);
   endfunction

   // Payload bits left once the tag is removed from the token.
   function automatic int data_width(input int width, input int flux);
      return width - $clog2(flux);
   endfunction

   // Counter width able to hold 0..depth.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_fwft.sv
// rtl/fifo_fwft.sv - first-word-fall-through FIFO with occupancy count
//
// Purpose: one per-flux buffer. The head word is always visible on rd_data.
// Ports:   clk, rst (sync active-low)
//          wr_en / wr_data  : push (ignored when full unless popping too)
//          rd_en            : pop (ignored when empty)
//          rd_data          : head word, don't-care while empty
//          empty, full      : status flags
//          count            : tokens held, 0..DEPTH
module fifo_fwft
   import ddf_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_en,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   input  logic                           rd_en,
   output logic [DATA_WIDTH-1:0]          rd_data,
   output logic                           empty,
   output logic                           full,
   output logic [cnt_width(DEPTH)-1:0]    count
);

   localparam int CNT_W = cnt_width(DEPTH);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   logic w_do_rd;
   logic w_do_wr;

   assign w_do_rd = rd_en && (r_count != '0);
   // A full buffer may still take a word when it frees a slot on the same edge.
   assign w_do_wr = wr_en && ((r_count != CNT_W'(DEPTH)) || w_do_rd);

   // Explicit wrap so that non power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= ptr_next(r_wr_ptr);
         if (w_do_rd) r_rd_ptr <= ptr_next(r_rd_ptr);
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; stale words are hidden behind the count.
   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
   end

   assign rd_data = r_mem[r_rd_ptr];
   assign empty   = (r_count == '0);
   assign full    = (r_count == CNT_W'(DEPTH));
   assign count   = r_count;

endmodule

// File: rtl/flux_demux_sink.sv
// rtl/flux_demux_sink.sv - tag-steered demultiplexer into per-flux FWFT buffers
//
// Purpose: accepts tagged tokens, strips the tag and queues the payload in
//          the buffer selected by the tag; illegal tags are dropped and flagged.
// Ports:   clk, rst (sync active-low)
//          in_port_write / in_port_datain / in_port_full : upstream token port
//          out_port_read / out_port_dataout / out_port_empty : per-flux pop ports
//          occupancy : per-flux counts, tag_err : one-cycle drop pulse
module flux_demux_sink
   import ddf_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int FLUX  = 2,
   parameter int DEPTH = 4
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      in_port_write,
   input  logic [WIDTH-1:0]                          in_port_datain,
   output logic                                      in_port_full,
   input  logic [FLUX-1:0]                           out_port_read,
   output logic [FLUX*data_width(WIDTH,FLUX)-1:0]    out_port_dataout,
   output logic [FLUX-1:0]                           out_port_empty,
   output logic [FLUX*cnt_width(DEPTH)-1:0]          occupancy,
   output logic                                      tag_err
);

   localparam int TAG_WIDTH  = tag_width(FLUX);
   localparam int DATA_WIDTH = data_width(WIDTH, FLUX);
   localparam int CNT_W      = cnt_width(DEPTH);

   logic [TAG_WIDTH-1:0]  w_tag;
   logic [DATA_WIDTH-1:0] w_payload;
   logic                  w_accept;
   logic                  w_tag_legal;
   logic [FLUX-1:0]       w_full_vec;
   logic                  r_tag_err;

   assign w_tag       = in_port_datain[WIDTH-1 -: TAG_WIDTH];
   assign w_payload   = in_port_datain[DATA_WIDTH-1:0];
   // Any full buffer blocks every write: the tag is unknown until the write.
   assign in_port_full = |w_full_vec;
   assign w_accept    = in_port_write && !in_port_full;
   assign w_tag_legal = (int'(w_tag) < FLUX);

   always_ff @(posedge clk) begin
      if (!rst) r_tag_err <= 1'b0;
      else      r_tag_err <= w_accept && !w_tag_legal;
   end

   assign tag_err = r_tag_err;

   for (genvar i = 0; i < FLUX; i++) begin : g_flux
      logic w_wr_en;

      assign w_wr_en = w_accept && w_tag_legal && (w_tag == TAG_WIDTH'(i));

      fifo_fwft #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (w_wr_en),
         .wr_data (w_payload),
         .rd_en   (out_port_read[i]),
         .rd_data (out_port_dataout[i*DATA_WIDTH +: DATA_WIDTH]),
         .empty   (out_port_empty[i]),
         .full    (w_full_vec[i]),
         .count   (occupancy[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_flux_demux_sink.sv
// tb/tb_flux_demux_sink.sv - directed self-checking bench for flux_demux_sink
module tb_flux_demux_sink;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // Instance A: FLUX=2, DATA_WIDTH=8, DEPTH=4 (CNT_W=3)
   logic        a_write = 1'b0;
   logic [8:0]  a_din   = '0;
   logic        a_full;
   logic [1:0]  a_read  = '0;
   logic [15:0] a_dout;
   logic [1:0]  a_empty;
   logic [5:0]  a_occ;
   logic        a_terr;

   // Instance B: FLUX=3, TAG_WIDTH=2, DATA_WIDTH=8, DEPTH=4
   logic        b_write = 1'b0;
   logic [9:0]  b_din   = '0;
   logic        b_full;
   logic [2:0]  b_read  = '0;
   logic [23:0] b_dout;
   logic [2:0]  b_empty;
   logic [8:0]  b_occ;
   logic        b_terr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   flux_demux_sink #(.WIDTH(9), .FLUX(2), .DEPTH(4)) u_dut_a (
      .clk              (clk),
      .rst              (rst),
      .in_port_write    (a_write),
      .in_port_datain   (a_din),
      .in_port_full     (a_full),
      .out_port_read    (a_read),
      .out_port_dataout (a_dout),
      .out_port_empty   (a_empty),
      .occupancy        (a_occ),
      .tag_err          (a_terr)
   );

   flux_demux_sink #(.WIDTH(10), .FLUX(3), .DEPTH(4)) u_dut_b (
      .clk              (clk),
      .rst              (rst),
      .in_port_write    (b_write),
      .in_port_datain   (b_din),
      .in_port_full     (b_full),
      .out_port_read    (b_read),
      .out_port_dataout (b_dout),
      .out_port_empty   (b_empty),
      .occupancy        (b_occ),
      .tag_err          (b_terr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset
      step(); step();
      rst = 1'b1;
      chk("rst_empty", 32'(a_empty), 32'h3);
      chk("rst_occ",   32'(a_occ),   32'h0);
      chk("rst_full",  32'(a_full),  32'h0);
      chk("rst_terr",  32'(a_terr),  32'h0);
      chk("rst_b_empty", 32'(b_empty), 32'h7);

      // Single-token routing to flux 1
      a_write = 1'b1; a_din = 9'h108;
      step();
      a_write = 1'b0;
      chk("route_empty", 32'(a_empty),      32'h1);
      chk("route_dout1", 32'(a_dout[15:8]), 32'h08);
      chk("route_occ1",  32'(a_occ[5:3]),   32'h1);
      chk("route_occ0",  32'(a_occ[2:0]),   32'h0);
      a_read = 2'b10;
      step();
      a_read = 2'b00;
      chk("route_pop_empty", 32'(a_empty), 32'h3);

      // Fill flux 0
      a_write = 1'b1;
      a_din = 9'h011; step();
      a_din = 9'h022; step();
      a_din = 9'h033; step();
      a_din = 9'h044; step();
      chk("fill_full", 32'(a_full),      32'h1);
      chk("fill_occ0", 32'(a_occ[2:0]),  32'h4);
      a_din = 9'h0AA; step();
      a_write = 1'b0;
      chk("blocked_occ0", 32'(a_occ[2:0]), 32'h4);
      chk("head0_11",     32'(a_dout[7:0]), 32'h11);

      // Pop flux 0 while full; concurrent tag-1 write must be blocked
      a_read = 2'b01; a_write = 1'b1; a_din = 9'h155;
      step();
      a_read = 2'b00; a_write = 1'b0;
      chk("popfull_occ0", 32'(a_occ[2:0]), 32'h3);
      chk("popfull_occ1", 32'(a_occ[5:3]), 32'h0);
      chk("popfull_full", 32'(a_full),     32'h0);
      chk("head0_22",     32'(a_dout[7:0]), 32'h22);
      a_read = 2'b01; step();
      chk("head0_33", 32'(a_dout[7:0]), 32'h33);
      step();
      chk("head0_44", 32'(a_dout[7:0]), 32'h44);
      step();
      a_read = 2'b00;
      chk("drain_empty", 32'(a_empty), 32'h3);
      // Read of an empty buffer is ignored
      a_read = 2'b11; step(); a_read = 2'b00;
      chk("empty_read_occ", 32'(a_occ), 32'h0);

      // Wrap-around on flux 1
      for (int k = 1; k <= 6; k++) begin
         a_write = 1'b1; a_din = {1'b1, 8'(k)};
         step();
         a_write = 1'b0;
         chk("wrap_dout1", 32'(a_dout[15:8]), 32'(k));
         chk("wrap_occ1",  32'(a_occ[5:3]),   32'h1);
         a_read = 2'b10;
         step();
         a_read = 2'b00;
         chk("wrap_empty1", 32'(a_empty[1]), 32'h1);
      end

      // Simultaneous write and pop on a non-full flux; independent other-flux read
      a_write = 1'b1; a_din = 9'h0A1; step();
      a_din = 9'h1B1; step();
      a_din = 9'h0A2; a_read = 2'b11; step();
      a_write = 1'b0; a_read = 2'b00;
      chk("wp_occ0",  32'(a_occ[2:0]),  32'h1);
      chk("wp_occ1",  32'(a_occ[5:3]),  32'h0);
      chk("wp_head0", 32'(a_dout[7:0]), 32'hA2);
      a_read = 2'b01; step(); a_read = 2'b00;

      // Reset mid-operation with a concurrent write
      a_write = 1'b1;
      a_din = 9'h0C1; step();
      a_din = 9'h0C2; step();
      a_din = 9'h0C3; step();
      chk("pre_rst_occ0", 32'(a_occ[2:0]), 32'h3);
      a_din = 9'h0C4; rst = 1'b0; a_read = 2'b01;
      step();
      rst = 1'b1; a_write = 1'b0; a_read = 2'b00;
      chk("midrst_empty", 32'(a_empty), 32'h3);
      chk("midrst_occ",   32'(a_occ),   32'h0);
      a_read = 2'b01; step(); a_read = 2'b00;
      chk("postrst_read_occ",   32'(a_occ),   32'h0);
      chk("postrst_read_empty", 32'(a_empty), 32'h3);

      // Illegal tag on the three-flux instance
      b_write = 1'b1; b_din = {2'b11, 8'h5A};
      step();
      b_write = 1'b0;
      chk("badtag_terr",  32'(b_terr),  32'h1);
      chk("badtag_empty", 32'(b_empty), 32'h7);
      chk("badtag_occ",   32'(b_occ),   32'h0);
      step();
      chk("badtag_pulse_end", 32'(b_terr), 32'h0);
      b_write = 1'b1; b_din = {2'b10, 8'h77};
      step();
      b_write = 1'b0;
      chk("tag2_empty", 32'(b_empty),        32'h3);
      chk("tag2_dout",  32'(b_dout[23:16]),  32'h77);
      chk("tag2_terr",  32'(b_terr),         32'h0);
      chk("tag2_occ2",  32'(b_occ[8:6]),     32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
